// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial_subtractor slice: FSM state encoding
// and the counter-width helper used to size the bit counter.
package serial_subtractor_pkg;

    // FSM state encoding shared by the serial arithmetic blocks
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, used to size the bit counter (CNT_W = clog2(WIDTH))
    function automatic int clog2_w(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = x ^ y ^ bin and the borrow
// out of that bit.
// Optional build macro SERIAL_SUBTRACTOR_ADD_MODE_EN adds a 'sub' select;
// with sub=0 the cell acts as a full adder and bout carries the carry-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    input  logic sub,
`endif
    output logic d,
    output logic bout
);

    logic borrow_s;
    logic carry_s;

    // Sum/difference bit plus borrow and carry terms for this position
    always_comb begin
        d        = x ^ y ^ bin;
        borrow_s = (~x & y) | (~(x ^ y) & bin);
        carry_s  = (x & y) | ((x ^ y) & bin);
    end

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    // Select borrow (subtract) or carry (add) as the propagated bit
    always_comb begin
        if (sub) begin
            bout = borrow_s;
        end else begin
            bout = carry_s;
        end
    end
`else
    // Subtract-only build: the carry term is not propagated
    always_comb begin
        bout = borrow_s | (carry_s & 1'b0);
    end
`endif

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit per
// clock through a single full_subtractor cell. Result and borrow-out are
// presented in parallel together with a one-cycle done pulse.
// Optional build macro SERIAL_SUBTRACTOR_ADD_MODE_EN adds a 'sub' input
// (captured with the operands) selecting subtract (1) or add (0).
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = clog2_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_s;
    logic [CNT_W-1:0] cnt_r;
    logic             br_r;
    logic             d_s;
    logic             br_s;
    logic             load_s;
    logic             step_s;
    logic             last_s;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    logic             sub_r;
`endif

    // Single arithmetic cell fed by the LSBs of the operand shift registers
    full_subtractor u_cell (
        .x    (sa_r[0]),
        .y    (sb_r[0]),
        .bin  (br_r),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        .sub  (sub_r),
`endif
        .d    (d_s),
        .bout (br_s)
    );

    // Next result word: the new bit enters from the MSB end
    always_comb begin
        res_s = {d_s, res_r[WIDTH-1:1]};
    end

    // Next-state and datapath control decode
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        step_s  = 1'b0;
        last_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    last_s  = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s = ST_RUN;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand/result shift registers, borrow, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_r  <= '0;
            sb_r  <= '0;
            res_r <= '0;
            cnt_r <= '0;
            br_r  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
            sub_r <= 1'b1;
`endif
        end else if (load_s) begin
            sa_r  <= a;
            sb_r  <= b;
            res_r <= '0;
            cnt_r <= '0;
            br_r  <= bin;
            busy  <= 1'b1;
            done  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
            sub_r <= sub;
`endif
        end else if (step_s) begin
            sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
            sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
            res_r <= res_s;
            cnt_r <= cnt_r + CNT_W'(1);
            br_r  <= br_s;
            if (last_s) begin
                diff <= res_s;
                bout <= br_s;
                done <= 1'b1;
                busy <= 1'b0;
            end else begin
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): stimulus pushes the
// expected {diff,bout} into a queue; a monitor pops and compares on done.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    logic         sub = 1'b1;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int compared = 0;
    int mismatched = 0;
    logic [W:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (done === 1'b1) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_done: got diff=%0h bout=%0b with no result expected", diff, bout);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if ({diff, bout} !== e) begin
                    mismatched++;
                    $display("FAIL result: got diff=%0h bout=%0b expected diff=%0h bout=%0b",
                             diff, bout, e[W:1], e[0]);
                end
            end
        end
    end

    // Drive a start pulse for one cycle (called at a negedge); optionally expect a result
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                         input logic expect_res, input logic [W-1:0] ed, input logic eb);
        a = ia;
        b = ib;
        bin = ibin;
        start = 1'b1;
        if (expect_res) exp_q.push_back({ed, eb});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting busy cycles; returns at the done negedge
    task automatic wait_done(output int busy_cnt);
        int cyc;
        busy_cnt = 0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int bc;
        logic saw_done;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_bout", {31'd0, bout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 5 - 3
        issue(8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0);
        wait_done(bc);
        check("busy_len_1", bc, 32'd8);
        @(negedge clk);
        check("done_pulse_1", {31'd0, done}, 32'd0);

        // 3 - 5 wraps with borrow
        issue(8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b1);
        wait_done(bc);
        check("busy_len_2", bc, 32'd8);
        @(negedge clk);

        // 0 - 0 - 1, then back-to-back FF - 0F - 1 issued during done
        issue(8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1);
        wait_done(bc);
        issue(8'hFF, 8'h0F, 1'b1, 1'b1, 8'hEF, 1'b0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(bc);
        check("busy_len_b2b", bc, 32'd8);
        repeat (4) @(negedge clk);
        check("hold_diff", {24'd0, diff}, 32'h0000_00EF);
        check("hold_bout", {31'd0, bout}, 32'd0);

        // start during RUN is ignored
        issue(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b0);
        @(negedge clk);
        @(negedge clk);
        issue(8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
        wait_done(bc);
        @(negedge clk);

        // reset aborts an operation in flight
        issue(8'hAA, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_diff", {24'd0, diff}, 32'd0);
        check("abort_bout", {31'd0, bout}, 32'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);

        // More subtract vectors
        issue(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1);
        wait_done(bc);
        @(negedge clk);
        issue(8'h80, 8'h7F, 1'b0, 1'b1, 8'h01, 1'b0);
        wait_done(bc);
        @(negedge clk);
        issue(8'hFF, 8'h01, 1'b0, 1'b1, 8'hFE, 1'b0);
        wait_done(bc);
        @(negedge clk);

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        // Add mode: FF + 01 carries out
        sub = 1'b0;
        issue(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1);
        wait_done(bc);
        check("busy_len_add", bc, 32'd8);
        @(negedge clk);
        issue(8'h12, 8'h34, 1'b1, 1'b1, 8'h47, 1'b0);
        wait_done(bc);
        @(negedge clk);
        sub = 1'b1;
        issue(8'hFF, 8'h01, 1'b0, 1'b1, 8'hFE, 1'b0);
        wait_done(bc);
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
